decode_stage_pipe: RTL and testbench

- Parametrised next-generation decode stage for the 5-stage MIPS pipeline.
- Contains the register file with WB write-through bypass, the instruction decoder, and the branch/jump redirect logic with forwarding.
- Adds a registered ID/EX output bundle with stall/flush bubble insertion and a bubble performance counter.
- Sits between the IF/ID register and the execute stage; hazard unit drives stall/flush/forward selects.

---
 rtl/decode_stage_pipe.sv | 190 +++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: register file with WB write-through, decoder, branch/jump
// redirect with forwarding, and a registered ID/EX bundle with bubble counting.
module decode_stage_pipe #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int RA_IDX = 31,
   parameter int CNT_W  = 16,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [31:0]      instrD,
   input  logic [XLEN-1:0]  pc_plus_4_decoded,
   input  logic             stall,
   input  logic             flush,
   input  logic             regWriteW,
   input  logic [AW-1:0]    write_register,
   input  logic [XLEN-1:0]  write_from_wb,
   input  logic             forwardAD,
   input  logic             forwardBD,
   input  logic [XLEN-1:0]  alu_out,
   output logic             pc_src,
   output logic [XLEN-1:0]  branch_target,
   output logic             jump,
   output logic [XLEN-1:0]  jump_target,
   output logic             jr,
   output logic [XLEN-1:0]  jr_target,
   output logic [4:0]       rs_d,
   output logic [4:0]       rt_d,
   output logic             ex_valid,
   output logic             ex_reg_write,
   output logic             ex_mem_to_reg,
   output logic             ex_mem_write,
   output logic             ex_alu_src,
   output logic             ex_reg_dst,
   output logic             ex_syscall,
   output logic [2:0]       ex_alu_ctrl,
   output logic [XLEN-1:0]  ex_rd1,
   output logic [XLEN-1:0]  ex_rd2,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic [4:0]       ex_rd,
   output logic [XLEN-1:0]  ex_imm,
   output logic [31:0]      ex_instr,
   output logic [XLEN-1:0]  sys_v0,
   output logic [XLEN-1:0]  sys_a0,
   output logic [CNT_W-1:0] bubble_count
);

   localparam logic [AW-1:0] RA_W = AW'(RA_IDX);

   typedef struct packed {
      logic       reg_write, mem_to_reg, mem_write, alu_src, reg_dst;
      logic       branch, bne, jmp, jal, jr, syscall;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   typedef struct packed {
      logic            valid, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, syscall;
      logic [2:0]      alu_ctrl;
      logic [XLEN-1:0] rd1, rd2;
      logic [4:0]      rs, rt, rd;
      logic [XLEN-1:0] imm;
      logic [31:0]     instr;
   } ex_t;

   ctrl_t            dec;
   ex_t              ex_q, ex_d;
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
   logic [XLEN-1:0]  rd1, rd2, op_a, op_b, imm;
   logic             active, link_we, bubble;

   assign rs_d = instrD[25:21];
   assign rt_d = instrD[20:16];
   assign imm  = {{(XLEN-16){instrD[15]}}, instrD[15:0]};

   always_comb begin
      dec = '0;
      case (instrD[31:26])
         6'h00: case (instrD[5:0])
            6'h20: begin dec.alu_ctrl = 3'b010; dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
            6'h22: begin dec.alu_ctrl = 3'b110; dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
            6'h24: begin dec.alu_ctrl = 3'b000; dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
            6'h25: begin dec.alu_ctrl = 3'b001; dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
            6'h2A: begin dec.alu_ctrl = 3'b111; dec.reg_dst = 1'b1; dec.reg_write = 1'b1; end
            6'h08: dec.jr = 1'b1;
            6'h0C: dec.syscall = 1'b1;
            default: ;
         endcase
         6'h23: begin dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = 3'b010; end
         6'h2B: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_ctrl = 3'b010; end
         6'h08: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = 3'b010; end
         6'h04: begin dec.branch = 1'b1; dec.alu_ctrl = 3'b110; end
         6'h05: begin dec.branch = 1'b1; dec.bne = 1'b1; dec.alu_ctrl = 3'b110; end
         6'h02: dec.jmp = 1'b1;
         6'h03: begin dec.jmp = 1'b1; dec.jal = 1'b1; end
         default: ;
      endcase
   end

   // Reads see a same-cycle WB write; the jal link port is not bypassed.
   function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
      if (a == 5'd0 || int'(a) >= NREGS) return '0;
      if (regWriteW && 5'(write_register) == a) return write_from_wb;
      return regs_q[a[AW-1:0]];
   endfunction

   always_comb begin
      rd1    = rf_read(rs_d);
      rd2    = rf_read(rt_d);
      sys_v0 = rf_read(5'd2);
      sys_a0 = rf_read(5'd4);
   end

   assign active        = id_valid & ~stall;
   assign op_a          = forwardAD ? alu_out : rd1;
   assign op_b          = forwardBD ? alu_out : rd2;
   assign pc_src        = active & dec.branch & (dec.bne ? (op_a != op_b) : (op_a == op_b));
   assign jump          = active & dec.jmp;
   assign jr            = active & dec.jr;
   assign jr_target     = op_a;
   assign branch_target = pc_plus_4_decoded + (imm << 2);
   assign jump_target   = {pc_plus_4_decoded[XLEN-1:28], instrD[25:0], 2'b00};
   assign link_we       = id_valid & dec.jal & ~stall & ~flush;

   // Link write is applied last so it wins over a WB write to the same register.
   always_comb begin
      regs_d = regs_q;
      if (regWriteW && write_register != '0) regs_d[write_register] = write_from_wb;
      if (link_we) regs_d[RA_W] = pc_plus_4_decoded + XLEN'(4);
   end

   assign bubble = stall | flush | ~id_valid;

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid      = 1'b1;
         ex_d.reg_write  = dec.reg_write;
         ex_d.mem_to_reg = dec.mem_to_reg;
         ex_d.mem_write  = dec.mem_write;
         ex_d.alu_src    = dec.alu_src;
         ex_d.reg_dst    = dec.reg_dst;
         ex_d.syscall    = dec.syscall;
         ex_d.alu_ctrl   = dec.alu_ctrl;
         ex_d.rd1        = rd1;
         ex_d.rd2        = rd2;
         ex_d.rs         = rs_d;
         ex_d.rt         = rt_d;
         ex_d.rd         = instrD[15:11];
         ex_d.imm        = imm;
         ex_d.instr      = instrD;
      end
      bubble_count_d = bubble_count_q;
      if ((stall | flush) && bubble_count_q != '1) bubble_count_d = bubble_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         ex_q           <= '0;
         bubble_count_q <= '0;
      end else begin
         regs_q         <= regs_d;
         ex_q           <= ex_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_reg_dst    = ex_q.reg_dst;
   assign ex_syscall    = ex_q.syscall;
   assign ex_alu_ctrl   = ex_q.alu_ctrl;
   assign ex_rd1        = ex_q.rd1;
   assign ex_rd2        = ex_q.rd2;
   assign ex_rs         = ex_q.rs;
   assign ex_rt         = ex_q.rt;
   assign ex_rd         = ex_q.rd;
   assign ex_imm        = ex_q.imm;
   assign ex_instr      = ex_q.instr;
   assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: expected ID/EX bundles come from a
// bench-side decoder and register-file model, queued per edge and popped after it.
module tb_decode_stage_pipe;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset, id_valid, stall, flush, regWriteW, forwardAD, forwardBD;
   logic [31:0]   instrD, pc_plus_4_decoded, write_from_wb, alu_out;
   logic [4:0]    write_register;
   logic          pc_src, jump, jr;
   logic [31:0]   branch_target, jump_target, jr_target;
   logic [4:0]    rs_d, rt_d;
   logic          ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_dst, ex_syscall;
   logic [2:0]    ex_alu_ctrl;
   logic [31:0]   ex_rd1, ex_rd2, ex_imm, ex_instr, sys_v0, sys_a0;
   logic [4:0]    ex_rs, ex_rt, ex_rd;
   logic [CW-1:0] bubble_count;

   decode_stage_pipe #(.XLEN(32), .NREGS(32), .RA_IDX(31), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .instrD(instrD),
      .pc_plus_4_decoded(pc_plus_4_decoded), .stall(stall), .flush(flush),
      .regWriteW(regWriteW), .write_register(write_register), .write_from_wb(write_from_wb),
      .forwardAD(forwardAD), .forwardBD(forwardBD), .alu_out(alu_out),
      .pc_src(pc_src), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
      .jr(jr), .jr_target(jr_target), .rs_d(rs_d), .rt_d(rt_d),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
      .ex_syscall(ex_syscall), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_instr(ex_instr),
      .sys_v0(sys_v0), .sys_a0(sys_a0), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v, rw, m2r, mw, alusrc, rdst, sc;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2;
      logic [4:0]  rs, rt, rd;
      logic [31:0] imm, instr;
   } ex_t;

   ex_t         sb[$];
   ex_t         exp_e, got_e, drop_e;
   logic [31:0] mrf [32];
   logic [CW-1:0] cnt_m;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (regWriteW && write_register == a) return write_from_wb;
      return mrf[a];
   endfunction

   function automatic ex_t exp_ex();
      ex_t e;
      e = '0;
      if (reset || stall || flush || !id_valid) return e;
      e.v = 1'b1; e.rs = instrD[25:21]; e.rt = instrD[20:16]; e.rd = instrD[15:11];
      e.imm = {{16{instrD[15]}}, instrD[15:0]}; e.instr = instrD;
      e.rd1 = mread(instrD[25:21]); e.rd2 = mread(instrD[20:16]);
      case (instrD[31:26])
         6'h00: case (instrD[5:0])
            6'h20: begin e.alu = 3'd2; e.rdst = 1; e.rw = 1; end
            6'h22: begin e.alu = 3'd6; e.rdst = 1; e.rw = 1; end
            6'h24: begin e.alu = 3'd0; e.rdst = 1; e.rw = 1; end
            6'h25: begin e.alu = 3'd1; e.rdst = 1; e.rw = 1; end
            6'h2A: begin e.alu = 3'd7; e.rdst = 1; e.rw = 1; end
            6'h0C: e.sc = 1;
            default: ;
         endcase
         6'h23: begin e.alusrc = 1; e.m2r = 1; e.rw = 1; e.alu = 3'd2; end
         6'h2B: begin e.alusrc = 1; e.mw = 1; e.alu = 3'd2; end
         6'h08: begin e.alusrc = 1; e.rw = 1; e.alu = 3'd2; end
         6'h04, 6'h05: e.alu = 3'd6;
         default: ;
      endcase
      return e;
   endfunction

   function automatic ex_t ex_now();
      ex_t g;
      g.v = ex_valid; g.rw = ex_reg_write; g.m2r = ex_mem_to_reg; g.mw = ex_mem_write;
      g.alusrc = ex_alu_src; g.rdst = ex_reg_dst; g.sc = ex_syscall; g.alu = ex_alu_ctrl;
      g.rd1 = ex_rd1; g.rd2 = ex_rd2; g.rs = ex_rs; g.rt = ex_rt; g.rd = ex_rd;
      g.imm = ex_imm; g.instr = ex_instr;
      return g;
   endfunction

   // One clock: queue the expected bundle, advance the models, then cross the edge.
   task automatic tick();
      sb.push_back(exp_ex());
      if (reset) begin
         for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
         cnt_m = '0;
      end else begin
         if (regWriteW && write_register != 5'd0) mrf[write_register] = write_from_wb;
         if (id_valid && instrD[31:26] == 6'h03 && !stall && !flush) mrf[31] = pc_plus_4_decoded + 32'd4;
         if ((stall || flush) && cnt_m != '1) cnt_m = cnt_m + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      id_valid = 0; regWriteW = 1; write_register = a; write_from_wb = d;
      tick();
      drop_e = sb.pop_front();
      regWriteW = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_e = sb.pop_front(); got_e = ex_now(); checks++;
         if (got_e !== exp_e) begin errors++; $display("FAIL reset_ex got %h exp %h", got_e, exp_e); end
      end
      checks++;
      if (bubble_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bubble_count); end
      reset = 0;
      id_valid = 1;
      for (int r = 0; r < 32; r++) begin
         instrD = {6'h00, 5'(r), 15'd0, 6'h08};
         #1; checks++;
         if (jr_target !== 32'd0 || jr !== 1'b1) begin
            errors++; $display("FAIL reset_rf r%0d got %h jr %b exp 0", r, jr_target, jr);
         end
      end
      id_valid = 0;
   endtask

   task automatic test_alu();
      logic [31:0] tbl [10];
      tbl = '{32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A, 32'h8C25FFFC,
              32'hAC220008, 32'h20267FFF, 32'hFC221820, 32'h0000000C, 32'h00200008};
      wb(5'd1, 32'd5); wb(5'd2, 32'd7); wb(5'd4, 32'h44);
      checks++;
      if (sys_v0 !== 32'd7 || sys_a0 !== 32'h44) begin
         errors++; $display("FAIL sys_regs got %h %h exp 7 44", sys_v0, sys_a0);
      end
      id_valid = 1; instrD = 32'h00221820;
      tick();
      exp_e = sb.pop_front(); got_e = ex_now(); checks++;
      if (got_e !== exp_e) begin errors++; $display("FAIL add_ex got %h exp %h", got_e, exp_e); end
      checks++;
      if (ex_rd1 !== 32'd5 || ex_rd2 !== 32'd7 || ex_alu_ctrl !== 3'b010 || ex_reg_dst !== 1'b1 || ex_valid !== 1'b1) begin
         errors++; $display("FAIL add_fields got %h %h %b %b %b exp 5 7 010 1 1", ex_rd1, ex_rd2, ex_alu_ctrl, ex_reg_dst, ex_valid);
      end
      foreach (tbl[i]) begin
         instrD = tbl[i];
         tick();
         exp_e = sb.pop_front(); got_e = ex_now(); checks++;
         if (got_e !== exp_e) begin errors++; $display("FAIL decode_%0d got %h exp %h", i, got_e, exp_e); end
      end
      id_valid = 0;
   endtask

   task automatic test_bypass();
      id_valid = 1; instrD = 32'h00221820;
      regWriteW = 1; write_register = 5'd1; write_from_wb = 32'hAA;
      tick();
      exp_e = sb.pop_front(); got_e = ex_now(); checks++;
      if (got_e !== exp_e || ex_rd1 !== 32'hAA) begin
         errors++; $display("FAIL bypass got %h exp %h rd1 exp aa", got_e, exp_e);
      end
      instrD = 32'h00001820; write_register = 5'd0; write_from_wb = 32'h55;
      tick();
      exp_e = sb.pop_front(); got_e = ex_now(); checks++;
      if (got_e !== exp_e || ex_rd1 !== 32'd0) begin
         errors++; $display("FAIL wb_r0 got %h exp %h rd1 exp 0", got_e, exp_e);
      end
      regWriteW = 0; instrD = 32'h00000008;
      #1; checks++;
      if (jr_target !== 32'd0) begin errors++; $display("FAIL r0_after got %h exp 0", jr_target); end
      id_valid = 0;
   endtask

   task automatic test_branch();
      wb(5'd1, 32'd9); wb(5'd2, 32'd3);
      id_valid = 1; pc_plus_4_decoded = 32'h100; alu_out = 32'd9; forwardBD = 1;
      instrD = 32'h10220004; #1; checks++;
      if (pc_src !== 1'b1 || branch_target !== 32'h110) begin
         errors++; $display("FAIL beq_fwd got %b %h exp 1 110", pc_src, branch_target);
      end
      instrD = 32'h14220004; #1; checks++;
      if (pc_src !== 1'b0) begin errors++; $display("FAIL bne_fwd got %b exp 0", pc_src); end
      forwardBD = 0; #1; checks++;
      if (pc_src !== 1'b1) begin errors++; $display("FAIL bne_nofwd got %b exp 1", pc_src); end
      instrD = 32'h1022FFFF; forwardBD = 1; #1; checks++;
      if (pc_src !== 1'b1 || branch_target !== 32'hFC) begin
         errors++; $display("FAIL beq_neg got %b %h exp 1 fc", pc_src, branch_target);
      end
      stall = 1; #1; checks++;
      if (pc_src !== 1'b0) begin errors++; $display("FAIL beq_stall got %b exp 0", pc_src); end
      stall = 0; forwardBD = 0; forwardAD = 1; alu_out = 32'h1234; instrD = 32'h00200008; #1; checks++;
      if (jr !== 1'b1 || jr_target !== 32'h1234) begin
         errors++; $display("FAIL jr_fwd got %b %h exp 1 1234", jr, jr_target);
      end
      forwardAD = 0; instrD = 32'h14220004;
      tick();
      exp_e = sb.pop_front(); got_e = ex_now(); checks++;
      if (got_e !== exp_e) begin errors++; $display("FAIL bne_ex got %h exp %h", got_e, exp_e); end
      id_valid = 0;
   endtask

   task automatic test_jal();
      id_valid = 1; instrD = 32'h0C000040; pc_plus_4_decoded = 32'h204;
      regWriteW = 1; write_register = 5'd31; write_from_wb = 32'h1234;
      #1; checks++;
      if (jump !== 1'b1 || jump_target !== 32'h100) begin
         errors++; $display("FAIL jal_redirect got %b %h exp 1 100", jump, jump_target);
      end
      tick();
      exp_e = sb.pop_front(); got_e = ex_now(); checks++;
      if (got_e !== exp_e) begin errors++; $display("FAIL jal_ex got %h exp %h", got_e, exp_e); end
      regWriteW = 0; instrD = 32'h03E00008; #1; checks++;
      if (jr_target !== 32'h208 || jr_target !== mrf[31]) begin
         errors++; $display("FAIL jal_link got %h exp 208", jr_target);
      end
      id_valid = 0;
   endtask

   task automatic test_bubbles();
      reset = 1; tick(); drop_e = sb.pop_front(); reset = 0;
      wb(5'd31, 32'h77);
      id_valid = 1; instrD = 32'h0C000040; pc_plus_4_decoded = 32'h300;
      for (int i = 0; i < 6; i++) begin
         stall = (i < 3 || i == 4); flush = (i >= 3 && i < 5);
         if (i == 5) id_valid = 0;
         tick();
         exp_e = sb.pop_front(); got_e = ex_now(); checks++;
         if (got_e !== exp_e || bubble_count !== cnt_m) begin
            errors++; $display("FAIL bubble_%0d got %h cnt %0d exp %h cnt %0d", i, got_e, bubble_count, exp_e, cnt_m);
         end
      end
      stall = 0; flush = 0; id_valid = 1; instrD = 32'h03E00008; #1; checks++;
      if (jr_target !== 32'h77) begin errors++; $display("FAIL stalled_jal got %h exp 77", jr_target); end
      id_valid = 0;
   endtask

   task automatic test_saturate_reset();
      id_valid = 1; instrD = 32'h00221820; stall = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         exp_e = sb.pop_front(); got_e = ex_now(); checks++;
         if (got_e !== exp_e || bubble_count !== cnt_m) begin
            errors++; $display("FAIL sat_%0d cnt %0d exp %0d", i, bubble_count, cnt_m);
         end
      end
      checks++;
      if (bubble_count !== {CW{1'b1}}) begin errors++; $display("FAIL sat_hold got %h exp ff", bubble_count); end
      stall = 0; instrD = 32'h0C000040; pc_plus_4_decoded = 32'h500;
      regWriteW = 1; write_register = 5'd7; write_from_wb = 32'h99; reset = 1;
      tick();
      exp_e = sb.pop_front(); got_e = ex_now(); checks++;
      if (got_e !== exp_e || got_e !== '0 || bubble_count !== '0) begin
         errors++; $display("FAIL mid_reset got %h cnt %0d exp 0 cnt 0", got_e, bubble_count);
      end
      reset = 0; regWriteW = 0; instrD = 32'h03E00008; #1; checks++;
      if (jr_target !== 32'd0) begin errors++; $display("FAIL reset_ra got %h exp 0", jr_target); end
      instrD = 32'h00E00008; #1; checks++;
      if (jr_target !== 32'd0) begin errors++; $display("FAIL reset_r7 got %h exp 0", jr_target); end
      id_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1; id_valid = 0; stall = 0; flush = 0; regWriteW = 0; forwardAD = 0; forwardBD = 0;
      instrD = '0; pc_plus_4_decoded = '0; write_from_wb = '0; alu_out = '0; write_register = '0;
      cnt_m = '0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      test_reset();
      test_alu();
      test_bypass();
      test_branch();
      test_jal();
      test_bubbles();
      test_saturate_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
